// File: rtl/latch_driver.sv
// Serialises a captured pattern LSB-first onto a CK-gated latch D input, one bit per HOLD clocks.
// Optional Q read-back mismatch counting is compiled in when LATCH_DRV_CHECK_EN is defined.
module latch_driver #(
  parameter int unsigned W    = 8,
  parameter int unsigned HOLD = 2,
  parameter int unsigned LW   = $clog2(W + 1),
  parameter int unsigned EW   = 8
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          START,
  input  logic [W-1:0]  PAT,
  input  logic [LW-1:0] LEN,
  input  logic          Q_IN,
  output logic          D_OUT,
  output logic          BUSY,
  output logic          DONE,
  output logic [EW-1:0] ERR_CNT
);

  localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_FIN
  } state_e;

  state_e        state_q;
  logic [W-1:0]  pat_q;
  logic [W-1:0]  pat_d;
  logic [LW-1:0] len_q;
  logic [LW-1:0] len_d;
  logic [LW-1:0] idx_q;
  logic [HW-1:0] hold_q;
  logic          d_q;
  logic          busy_q;
  logic          done_q;
  logic [EW-1:0] err_q;
  logic [EW-1:0] err_d;

  // The pattern is shifted right each bit, so the bit on D_OUT is always pat_q[0].
  always_comb begin
    pat_d = pat_q >> 1;
    len_d = (LEN > LW'(W)) ? LW'(W) : LEN;
  end

`ifdef LATCH_DRV_CHECK_EN
  always_comb begin
    err_d = err_q;
    if ((Q_IN != pat_q[0]) && (err_q != '1)) begin
      err_d = err_q + EW'(1);
    end
  end
`else
  logic unused_q_in;
  assign unused_q_in = Q_IN;
  assign err_d       = '0;
`endif

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q <= S_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      d_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          d_q    <= 1'b0;
          busy_q <= 1'b0;
          if (START) begin
            pat_q  <= PAT;
            len_q  <= len_d;
            idx_q  <= '0;
            hold_q <= '0;
            err_q  <= '0;
            if (len_d != '0) begin
              busy_q  <= 1'b1;
              d_q     <= PAT[0];
              state_q <= S_DRIVE;
            end else begin
              state_q <= S_FIN;
            end
          end
        end
        S_DRIVE: begin
          // Q_IN is sampled at the bit boundary: the latch closed on the preceding low phase.
          if (hold_q == HW'(HOLD - 1)) begin
            hold_q <= '0;
            err_q  <= err_d;
            if (idx_q == len_q - LW'(1)) begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              d_q     <= 1'b0;
            end else begin
              idx_q <= idx_q + LW'(1);
              pat_q <= pat_d;
              d_q   <= pat_d[0];
            end
          end else begin
            hold_q <= hold_q + HW'(1);
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          d_q     <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign D_OUT   = d_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR_CNT = err_q;

endmodule

// File: tb/tb_latch_driver.sv
// Scoreboard bench for latch_driver: stimulus queues expected D_OUT samples and DONE events,
// a negedge monitor pops and compares them. A CK-gated latch model closes the Q_IN loop.
module tb_latch_driver;

  localparam int unsigned W    = 8;
  localparam int unsigned HOLD = 2;
  localparam int unsigned LW   = 4;
  localparam int unsigned EW   = 8;

`ifdef LATCH_DRV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          CK = 1'b0;
  logic          RST;
  logic          START;
  logic [W-1:0]  PAT;
  logic [LW-1:0] LEN;
  logic          Q_IN;
  logic          D_OUT;
  logic          BUSY;
  logic          DONE;
  logic [EW-1:0] ERR_CNT;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   qmode    = 0;
  logic q_lat    = 1'b0;

  typedef struct {
    int   done_edge;
    int   err;
  } exp_t;

  exp_t exp_q[$];
  bit   dq[$];

  latch_driver #(.W(W), .HOLD(HOLD), .EW(EW)) dut (
    .CK(CK), .RST(RST), .START(START), .PAT(PAT), .LEN(LEN), .Q_IN(Q_IN),
    .D_OUT(D_OUT), .BUSY(BUSY), .DONE(DONE), .ERR_CNT(ERR_CNT)
  );

  always #5 CK = ~CK;
  always @(posedge CK) cyc <= cyc + 1;

  // Latch transparent while CK is high, holding through the low phase.
  always @(CK or D_OUT) if (CK) q_lat <= D_OUT;
  assign Q_IN = (qmode == 0) ? q_lat : (qmode == 1) ? 1'b0 : 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge CK) begin
    if (BUSY) begin
      if (dq.size() == 0) begin
        chk("busy_unexpected", 1, 0);
      end else begin
        bit b;
        b = dq.pop_front();
        chk("d_out", int'(D_OUT), int'(b));
      end
    end
    if (DONE) begin
      if (exp_q.size() == 0) begin
        chk("done_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_edge", cyc, e.done_edge);
        chk("err_cnt", int'(ERR_CNT), e.err);
      end
    end
  end

  task automatic step();
    @(posedge CK);
    #2;
  endtask

  task automatic start_run(input logic [7:0] p, input int len, input int qm, input int experr);
    int   k;
    int   lc;
    exp_t e;
    qmode = qm;
    START = 1'b1;
    PAT   = p;
    LEN   = LW'(len);
    k     = cyc + 1;
    lc    = (len > int'(W)) ? int'(W) : len;
    e.done_edge = k + lc * int'(HOLD) + 1;
    e.err       = CHK ? experr : 0;
    exp_q.push_back(e);
    for (int i = 0; i < lc; i++)
      for (int h = 0; h < int'(HOLD); h++) dq.push_back(p[i]);
    step();
    START = 1'b0;
    PAT   = ~p;
    LEN   = LW'(len ^ 5);
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || dq.size() != 0) && n < max) begin
      step();
      n++;
    end
    chk("drain_pending", exp_q.size() + dq.size(), 0);
    step();
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST   = 1'b1;
    START = 1'b0;
    PAT   = '0;
    LEN   = '0;
    step();
    step();
    chk("rst_d_out", int'(D_OUT), 0);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    chk("rst_err", int'(ERR_CNT), 0);
    RST = 1'b0;
    step();

    start_run(8'hAA, 8, 0, 0);
    drain(40);
    start_run(8'hAA, 8, 1, 4);
    drain(40);
    step();
    chk("err_persist", int'(ERR_CNT), CHK ? 4 : 0);
    start_run(8'h00, 8, 2, 8);
    drain(40);
    start_run(8'h5A, 0, 0, 0);
    drain(10);
    start_run(8'h3C, 12, 0, 0);
    drain(40);

    // START pulsed at k+5 with a different pattern must not disturb the run.
    start_run(8'hAA, 8, 0, 0);
    repeat (4) step();
    START = 1'b1;
    PAT   = 8'hFF;
    LEN   = LW'(8);
    step();
    START = 1'b0;
    drain(40);

    // Abort a run with RST at k+7, then restart at k+8.
    start_run(8'hAA, 8, 1, 0);
    repeat (6) step();
    chk("err_pre_rst", int'(ERR_CNT), CHK ? 1 : 0);
    RST = 1'b1;
    step();
    exp_q.delete();
    dq.delete();
    chk("abort_d_out", int'(D_OUT), 0);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_done", int'(DONE), 0);
    chk("abort_err", int'(ERR_CNT), 0);
    RST = 1'b0;
    start_run(8'h81, 3, 0, 0);
    drain(40);

    chk("leftover", exp_q.size() + dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
